// File: rtl/vedic_mul8_seq.sv
// vedic_mul8_seq: sequential 8x8 unsigned multiplier that reuses one 4x4
// Vedic partial-product unit over four cycles. The running sum is kept in
// carry-save form and resolved by a single 16-bit add before presentation.
module vedic_mul8_seq #(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PP0     = 3'd1,
        ST_PP1     = 3'd2,
        ST_PP2     = 3'd3,
        ST_PP3     = 3'd4,
        ST_RESOLVE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] sum_r;
    logic [15:0] carry_r;
    logic [15:0] p_r;

    logic [3:0]  nib_a_s;
    logic [3:0]  nib_b_s;
    logic [7:0]  pp_s;
    logic [15:0] pp_ext_s;
    logic [15:0] csa_sum_s;
    logic [15:0] csa_carry_s;
    logic        accept_s;
    logic        zero_hit_s;

    // 2x2 Vedic block: vertical and crosswise terms of two 2-bit operands.
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic t_lo;
        logic t_x1;
        logic t_x2;
        logic t_hi;
        logic c1;
        t_lo = x[0] & y[0];
        t_x1 = x[1] & y[0];
        t_x2 = x[0] & y[1];
        t_hi = x[1] & y[1];
        c1   = t_x1 & t_x2;
        return {t_hi & c1, t_hi ^ c1, t_x1 ^ t_x2, t_lo};
    endfunction

    // 4x4 Vedic block built from four 2x2 blocks and an aligned sum.
    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        q0 = vedic2(x[1:0], y[1:0]);
        q1 = vedic2(x[3:2], y[1:0]);
        q2 = vedic2(x[1:0], y[3:2]);
        q3 = vedic2(x[3:2], y[3:2]);
        return {4'h0, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'h0};
    endfunction

    assign accept_s   = in_valid && (state_r == ST_IDLE);
    assign zero_hit_s = ZERO_SKIP && ((a == 8'h00) || (b == 8'h00));

    // Select the nibble pair and alignment for the current partial product.
    always_comb begin
        nib_a_s  = 4'h0;
        nib_b_s  = 4'h0;
        pp_ext_s = 16'h0000;
        case (state_r)
            ST_PP0: begin
                nib_a_s = a_r[3:0];
                nib_b_s = b_r[3:0];
            end
            ST_PP1: begin
                nib_a_s = a_r[7:4];
                nib_b_s = b_r[3:0];
            end
            ST_PP2: begin
                nib_a_s = a_r[3:0];
                nib_b_s = b_r[7:4];
            end
            ST_PP3: begin
                nib_a_s = a_r[7:4];
                nib_b_s = b_r[7:4];
            end
            default: begin
                nib_a_s = 4'h0;
                nib_b_s = 4'h0;
            end
        endcase
        pp_s = vedic4(nib_a_s, nib_b_s);
        case (state_r)
            ST_PP0:  pp_ext_s = {8'h00, pp_s};
            ST_PP1:  pp_ext_s = {4'h0, pp_s, 4'h0};
            ST_PP2:  pp_ext_s = {4'h0, pp_s, 4'h0};
            ST_PP3:  pp_ext_s = {pp_s, 8'h00};
            default: pp_ext_s = 16'h0000;
        endcase
    end

    // 3:2 carry-save step; the product never exceeds 16 bits so the
    // shifted-out carry bit is always zero and can be dropped.
    always_comb begin
        logic [15:0] maj;
        maj         = (sum_r & carry_r) | (sum_r & pp_ext_s) | (carry_r & pp_ext_s);
        csa_sum_s   = sum_r ^ carry_r ^ pp_ext_s;
        csa_carry_s = {maj[14:0], 1'b0};
    end

    // Next-state sequencing of the partial-product schedule and handshake.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (zero_hit_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_PP0;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PP0:     state_nx_s = ST_PP1;
            ST_PP1:     state_nx_s = ST_PP2;
            ST_PP2:     state_nx_s = ST_PP3;
            ST_PP3:     state_nx_s = ST_RESOLVE;
            ST_RESOLVE: state_nx_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default:    state_nx_s = ST_IDLE;
        endcase
    end

    // State, operand latch, carry-save accumulator and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            sum_r   <= 16'h0000;
            carry_r <= 16'h0000;
            p_r     <= 16'h0000;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= b;
                        sum_r   <= 16'h0000;
                        carry_r <= 16'h0000;
                        if (zero_hit_s) begin
                            p_r <= 16'h0000;
                        end
                    end
                end
                ST_PP0, ST_PP1, ST_PP2, ST_PP3: begin
                    sum_r   <= csa_sum_s;
                    carry_r <= csa_carry_s;
                end
                ST_RESOLVE: p_r <= sum_r + carry_r;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign p         = p_r;

endmodule

// File: tb/tb_vedic_mul8_seq.sv
// Directed and randomised checks of vedic_mul8_seq. Two instances share the
// stimulus: one with zero-skip disabled (main) and one with it enabled.
module tb_vedic_mul8_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;

    logic        in_ready_m, out_valid_m, busy_m;
    logic [15:0] p_m;
    logic        in_ready_z, out_valid_z, busy_z;
    logic [15:0] p_z;

    logic        sel = 1'b0;
    logic        ir_o, ov_o, bz_o;
    logic [15:0] p_o;

    int nchk = 0;
    int nerr = 0;

    vedic_mul8_seq #(.ZERO_SKIP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .a(a), .b(b), .out_valid(out_valid_m), .out_ready(out_ready),
        .p(p_m), .busy(busy_m)
    );

    vedic_mul8_seq #(.ZERO_SKIP(1'b1)) dut_zs (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .a(a), .b(b), .out_valid(out_valid_z), .out_ready(out_ready),
        .p(p_z), .busy(busy_z)
    );

    assign ir_o = sel ? in_ready_z  : in_ready_m;
    assign ov_o = sel ? out_valid_z : out_valid_m;
    assign bz_o = sel ? busy_z      : busy_m;
    assign p_o  = sel ? p_z         : p_m;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the selected instance; called at posedge+1.
    task automatic txn(input logic [7:0] ta, input logic [7:0] tb_op, input int stall,
                       input logic [15:0] expp, input int explat, input string tag);
        int lat;
        a = ta;
        b = tb_op;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb_op;
        lat = 0;
        while (!ov_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, explat);
        chk({tag, ".p"}, {16'h0000, p_o}, {16'h0000, expp});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, {31'd0, ov_o}, 32'd1);
            chk({tag, ".hold_p"}, {16'h0000, p_o}, {16'h0000, expp});
            chk({tag, ".hold_busy"}, {31'd0, bz_o}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".consumed_valid"}, {31'd0, ov_o}, 32'd0);
        chk({tag, ".in_ready_back"}, {31'd0, ir_o}, 32'd1);
        chk({tag, ".busy_clear"}, {31'd0, bz_o}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        // Reset state
        #12;
        chk("rst.in_ready", {31'd0, in_ready_m}, 32'd1);
        chk("rst.busy", {31'd0, busy_m}, 32'd0);
        chk("rst.out_valid", {31'd0, out_valid_m}, 32'd0);
        chk("rst.p", {16'h0000, p_m}, 32'd0);
        chk("rst.zs_in_ready", {31'd0, in_ready_z}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Maximum operands
        txn(8'hFF, 8'hFF, 0, 16'hFE01, 5, "ff_ff");
        // Backpressure for 10 cycles
        txn(8'h0A, 8'h0C, 10, 16'h0078, 5, "bp");

        // Zero-skip path, then the same stimulus without zero-skip
        sel = 1'b1;
        txn(8'h00, 8'h5A, 0, 16'h0000, 0, "zs_on");
        sel = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("zs_drain.busy", {31'd0, busy_m}, 32'd0);
        txn(8'h00, 8'h5A, 0, 16'h0000, 5, "zs_off");

        // in_valid held with changing operands while busy
        a = 8'h12;
        b = 8'h34;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
        end
        chk("hold_iv.valid", {31'd0, out_valid_m}, 32'd1);
        chk("hold_iv.p", {16'h0000, p_m}, 32'h000003A8);
        @(posedge clk); #1;
        chk("hold_iv.no_accept_on_consume", {31'd0, busy_m}, 32'd0);
        chk("hold_iv.in_ready", {31'd0, in_ready_m}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Reset during PP2
        a = 8'hC3;
        b = 8'h7E;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort.busy_before", {31'd0, busy_m}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", {31'd0, out_valid_m}, 32'd0);
        chk("abort.p", {16'h0000, p_m}, 32'd0);
        chk("abort.busy", {31'd0, busy_m}, 32'd0);
        chk("abort.in_ready", {31'd0, in_ready_m}, 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(8'h03, 8'h05, 0, 16'h000F, 5, "after_abort");

        // Random pairs with random backpressure
        for (int i = 0; i < 3000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            txn(ra, rb, int'($urandom_range(0, 2)), 16'(ra) * 16'(rb), 5, "rand");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
